// File: rtl/char_grid_ctrl.sv
// Text overlay for a VGA pixel stream: a 16x16 grid of 8x16 glyphs placed at (X_POS, Y_POS).
// A three-stage pipeline looks up the character code (char ROM) and then the glyph row
// (font ROM), and draws TEXT_COLOR over the background on lit glyph pixels. Grid row 15
// blinks with a half-period of BLINK_FRAMES frames. The overlay is enabled per frame.
//
// Ports:
//   clk, rst_n                    pixel clock, asynchronous active-low reset
//   enable                        overlay request, sampled at each vsync rising edge
//   hcount_in .. rgb_in           incoming VGA counters, timing and background pixel
//   char_xy / char_code           grid address {row, col} to char ROM / its combinational data
//   font_addr / font_row          {char_code, line} to font ROM / its combinational data
//   hcount_out .. rgb_out         VGA stream delayed by exactly three cycles
module char_grid_ctrl #(
  parameter logic [10:0] X_POS        = 11'd0,
  parameter logic [10:0] Y_POS        = 11'd0,
  parameter logic [11:0] TEXT_COLOR   = 12'hfff,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [7:0]  char_xy,
  input  logic [6:0]  char_code,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_row,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [7:0]  LAST_FRAME = 8'(BLINK_FRAMES - 1);
  localparam logic [11:0] X_LO       = {1'b0, X_POS};
  localparam logic [11:0] X_HI       = {1'b0, X_POS} + 12'd128;
  localparam logic [11:0] Y_LO       = {1'b0, Y_POS};
  localparam logic [11:0] Y_HI       = {1'b0, Y_POS} + 12'd256;

  // Timing bundle: {hcount, vcount, hsync, vsync, hblnk, vblnk}
  localparam int unsigned TW = 26;

  logic [TW-1:0] tim_in, tim_d1, tim_d2, tim_d3;
  logic [11:0]   rgb_d1, rgb_d2, rgb_q;

  // Frame-rate state
  logic       vsync_prev_q;
  logic       overlay_q;
  logic       blink_q;
  logic [7:0] frame_cnt_q;
  logic       frame_start;

  // Stage 1
  logic [7:0] char_xy_q;
  logic [3:0] line1_q;
  logic [2:0] bit1_q;
  logic       win1_q, ov1_q, blink1_q;

  // Stage 2
  logic [10:0] font_addr_q;
  logic [2:0]  bit2_q;
  logic        win2_q, ov2_q, blink2_q, row15_2_q;

  logic        in_win;
  logic [10:0] rx, ry;
  logic        lit;

  assign tim_in = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};

  // 12-bit compares so a window near 2047 does not wrap
  assign in_win = ({1'b0, hcount_in} >= X_LO) && ({1'b0, hcount_in} < X_HI) &&
                  ({1'b0, vcount_in} >= Y_LO) && ({1'b0, vcount_in} < Y_HI);
  assign rx = hcount_in - X_POS;
  assign ry = vcount_in - Y_POS;

  assign frame_start = vsync_in & ~vsync_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev_q <= 1'b0;
      overlay_q    <= 1'b0;
      blink_q      <= 1'b0;
      frame_cnt_q  <= 8'd0;
    end else begin
      vsync_prev_q <= vsync_in;
      if (frame_start) begin
        overlay_q <= enable;
        if (frame_cnt_q == LAST_FRAME) begin
          frame_cnt_q <= 8'd0;
          blink_q     <= ~blink_q;
        end else begin
          frame_cnt_q <= frame_cnt_q + 8'd1;
        end
      end
    end
  end

  // Overlay and blink state are captured with the pixel in stage 1, so a frame start only
  // affects pixels entering the pipeline after that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_xy_q   <= 8'h00;
      line1_q     <= 4'h0;
      bit1_q      <= 3'd0;
      win1_q      <= 1'b0;
      ov1_q       <= 1'b0;
      blink1_q    <= 1'b0;
      font_addr_q <= 11'd0;
      bit2_q      <= 3'd0;
      win2_q      <= 1'b0;
      ov2_q       <= 1'b0;
      blink2_q    <= 1'b0;
      row15_2_q   <= 1'b0;
      tim_d1      <= '0;
      tim_d2      <= '0;
      tim_d3      <= '0;
      rgb_d1      <= 12'h000;
      rgb_d2      <= 12'h000;
      rgb_q       <= 12'h000;
    end else begin
      char_xy_q   <= in_win ? {ry[7:4], rx[6:3]} : 8'h00;
      line1_q     <= ry[3:0];
      bit1_q      <= rx[2:0];
      win1_q      <= in_win;
      ov1_q       <= overlay_q;
      blink1_q    <= blink_q;

      font_addr_q <= {char_code, line1_q};
      bit2_q      <= bit1_q;
      win2_q      <= win1_q;
      ov2_q       <= ov1_q;
      blink2_q    <= blink1_q;
      row15_2_q   <= (char_xy_q[7:4] == 4'hf);

      tim_d1      <= tim_in;
      tim_d2      <= tim_d1;
      tim_d3      <= tim_d2;
      rgb_d1      <= rgb_in;
      rgb_d2      <= rgb_d1;
      rgb_q       <= lit ? TEXT_COLOR : rgb_d2;
    end
  end

  // Blanking taken from the stage-2-aligned timing, never from the live inputs
  always_comb begin
    lit = win2_q && font_row[3'd7 - bit2_q] && ov2_q &&
          !(tim_d2[1] || tim_d2[0]) && !(row15_2_q && blink2_q);
  end

  assign char_xy   = char_xy_q;
  assign font_addr = font_addr_q;
  assign rgb_out   = rgb_q;
  assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = tim_d3;

endmodule

// File: tb/tb_char_grid_ctrl.sv
module tb_char_grid_ctrl;

  localparam logic [10:0] XP = 11'd0;
  localparam logic [10:0] YP = 11'd0;
  localparam logic [11:0] TC = 12'ha5c;
  localparam int          BF = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [7:0]  char_xy;
  logic [6:0]  char_code;
  logic [10:0] font_addr;
  logic [7:0]  font_row;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic        all_ones = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0]  xy;
    logic [10:0] fa;
    logic [11:0] rgb;
    logic [25:0] tim;
  } exp_t;

  exp_t q[$];

  // Reference frame state
  logic m_ov = 1'b0, m_vs_prev = 1'b0, m_phase = 1'b0;
  int   m_cnt = 0;

  always #5 clk = ~clk;

  function automatic logic [6:0] rom_char(input logic [7:0] a);
    return a[6:0] ^ {a[7], 6'h2b};
  endfunction

  function automatic logic [7:0] rom_font(input logic [10:0] a);
    return {a[3:0], a[10:7]} ^ {a[6:0], a[7]} ^ 8'h5a;
  endfunction

  assign char_code = rom_char(char_xy);
  assign font_row  = all_ones ? 8'hff : rom_font(font_addr);

  char_grid_ctrl #(
    .X_POS(XP), .Y_POS(YP), .TEXT_COLOR(TC), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .char_xy(char_xy), .char_code(char_code),
    .font_addr(font_addr), .font_row(font_row),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One pixel per cycle; expected outputs are queued and popped three edges later.
  task automatic pix(input logic [10:0] hc, input logic [10:0] vc, input logic [1:0] sy,
                     input logic [1:0] bl, input logic [11:0] rgb);
    exp_t        e, r;
    logic [10:0] rx, ry;
    logic [7:0]  row;
    logic        inw, lit;
    hcount_in = hc; vcount_in = vc;
    {hsync_in, vsync_in} = sy;
    {hblnk_in, vblnk_in} = bl;
    rgb_in = rgb;
    inw = ({1'b0, hc} >= {1'b0, XP}) && ({1'b0, hc} < {1'b0, XP} + 12'd128) &&
          ({1'b0, vc} >= {1'b0, YP}) && ({1'b0, vc} < {1'b0, YP} + 12'd256);
    rx = hc - XP;
    ry = vc - YP;
    e.xy  = inw ? {ry[7:4], rx[6:3]} : 8'h00;
    e.fa  = {rom_char(e.xy), ry[3:0]};
    row   = all_ones ? 8'hff : rom_font(e.fa);
    lit   = inw && row[3'd7 - rx[2:0]] && m_ov && (bl == 2'b00) &&
            !((e.xy[7:4] == 4'hf) && m_phase);
    e.rgb = lit ? TC : rgb;
    e.tim = {hc, vc, sy, bl};
    if (sy[0] && !m_vs_prev) begin
      m_ov = enable;
      if (m_cnt == BF - 1) begin
        m_cnt   = 0;
        m_phase = ~m_phase;
      end else begin
        m_cnt++;
      end
    end
    m_vs_prev = sy[0];
    q.push_back(e);
    @(posedge clk);
    #1;
    check("char_xy", {24'd0, char_xy}, {24'd0, q[$].xy});
    check("font_addr", {21'd0, font_addr}, {21'd0, q[q.size()-2].fa});
    if (q.size() >= 3) begin
      r = q.pop_front();
      check("rgb_out", {20'd0, rgb_out}, {20'd0, r.rgb});
      check("timing_out", {6'd0, hcount_out, vcount_out, hsync_out, vsync_out,
                           hblnk_out, vblnk_out}, {6'd0, r.tim});
    end
  endtask

  task automatic do_reset();
    exp_t z;
    rst_n = 1'b0;
    #1;
    check("rst_char_xy", {24'd0, char_xy}, 32'd0);
    check("rst_font_addr", {21'd0, font_addr}, 32'd0);
    check("rst_rgb_out", {20'd0, rgb_out}, 32'd0);
    check("rst_timing_out", {6'd0, hcount_out, vcount_out, hsync_out, vsync_out,
                             hblnk_out, vblnk_out}, 32'd0);
    m_ov = 1'b0; m_vs_prev = 1'b0; m_phase = 1'b0; m_cnt = 0;
    q.delete();
    // Reset pipeline contents: char_xy=0 and line 0 feed the font address after release
    z.xy = 8'h00; z.fa = {rom_char(8'h00), 4'h0}; z.rgb = 12'h000; z.tim = '0;
    q.push_back(z);
    q.push_back(z);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic frame_start();
    pix(11'd300, 11'd300, 2'b00, 2'b11, 12'h111);
    pix(11'd300, 11'd300, 2'b01, 2'b11, 12'h222);
    pix(11'd301, 11'd300, 2'b00, 2'b11, 12'h333);
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) pix(11'd400, 11'd400, 2'b00, 2'b11, 12'h0f0);
  endtask

  typedef struct {
    logic [10:0] hc;
    logic [10:0] vc;
    logic [1:0]  bl;
    logic [11:0] rgb;
    logic [7:0]  xy;
  } vec_t;

  vec_t vt[12];

  initial begin
    vt[0]  = '{11'd8,    11'd17,   2'b00, 12'h123, 8'h11};
    vt[1]  = '{11'd128,  11'd17,   2'b00, 12'h456, 8'h00};
    vt[2]  = '{11'd0,    11'd0,    2'b00, 12'h789, 8'h00};
    vt[3]  = '{11'd127,  11'd255,  2'b00, 12'habc, 8'hff};
    vt[4]  = '{11'd0,    11'd256,  2'b00, 12'hdef, 8'h00};
    vt[5]  = '{11'd40,   11'd224,  2'b00, 12'h321, 8'he5};
    vt[6]  = '{11'd7,    11'd15,   2'b00, 12'h654, 8'h00};
    vt[7]  = '{11'd64,   11'd100,  2'b00, 12'h987, 8'h68};
    vt[8]  = '{11'd2047, 11'd2047, 2'b00, 12'hcba, 8'h00};
    vt[9]  = '{11'd127,  11'd0,    2'b00, 12'hfed, 8'h0f};
    vt[10] = '{11'd16,   11'd32,   2'b10, 12'h0aa, 8'h22};
    vt[11] = '{11'd16,   11'd32,   2'b01, 12'h0bb, 8'h22};

    // Reset, then overlay on with font driven from the hashed ROM
    do_reset();
    enable = 1'b1;
    frame_start();
    foreach (vt[i]) begin
      pix(vt[i].hc, vt[i].vc, 2'b00, vt[i].bl, vt[i].rgb);
      check("table_xy", {24'd0, char_xy}, {24'd0, vt[i].xy});
    end
    for (int x = 0; x < 16; x++) pix(11'(x), 11'd33, 2'b00, 2'b00, 12'h5a5);
    flush();

    // Solid font: just outside the window must pass the background through
    all_ones = 1'b1;
    pix(11'd128, 11'd17, 2'b00, 2'b00, 12'h246);
    pix(11'd127, 11'd17, 2'b00, 2'b00, 12'h246);
    pix(11'd128, 11'd255, 2'b00, 2'b00, 12'h246);

    // Enable dropped mid-frame: text continues until the next frame start
    enable = 1'b0;
    pix(11'd10, 11'd20, 2'b00, 2'b00, 12'h135);
    pix(11'd11, 11'd20, 2'b00, 2'b00, 12'h135);
    frame_start();
    for (int x = 0; x < 8; x++) pix(11'(x * 9), 11'(x * 17), 2'b00, 2'b00, 12'h975);
    flush();

    // Frame start on the last window pixel: only later pixels see the new enable
    enable = 1'b1;
    frame_start();
    enable = 1'b0;
    pix(11'd127, 11'd254, 2'b00, 2'b00, 12'h404);
    pix(11'd127, 11'd255, 2'b01, 2'b00, 12'h505);
    pix(11'd0, 11'd0, 2'b01, 2'b00, 12'h606);
    pix(11'd1, 11'd0, 2'b00, 2'b00, 12'h707);
    flush();

    // Blink: row 15 hidden while phase is 1, row 14 always drawn
    do_reset();
    enable = 1'b1;
    for (int f = 0; f < 5; f++) begin
      frame_start();
      pix(11'd8, 11'd245, 2'b00, 2'b00, 12'h0c0);
      pix(11'd8, 11'd230, 2'b00, 2'b00, 12'h0c0);
      pix(11'd100, 11'd255, 2'b00, 2'b00, 12'h0c0);
      flush();
    end

    // Reset pulse mid-line: overlay off until the next frame start
    pix(11'd20, 11'd40, 2'b00, 2'b00, 12'h777);
    pix(11'd21, 11'd40, 2'b00, 2'b00, 12'h778);
    do_reset();
    for (int x = 22; x < 30; x++) pix(11'(x), 11'd40, 2'b00, 2'b00, 12'h779);
    frame_start();
    for (int x = 22; x < 26; x++) pix(11'(x), 11'd40, 2'b00, 2'b00, 12'h77a);
    flush();

    // Random stream over two frames
    all_ones = 1'b0;
    for (int i = 0; i < 600; i++) begin
      pix(11'($urandom_range(0, 200)), 11'($urandom_range(0, 300)),
          {1'($urandom_range(0, 1)), 1'((i % 300) < 10)},
          {1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0)},
          12'($urandom));
    end
    flush();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
